dio_in_conditioner: RTL and testbench

// - Sits directly downstream of the DIO tristate pad buffers; consumes the raw DIO_x_in pin readback.
// - Per pin: 2-FF synchroniser, programmable glitch filter, rise/fall pulses, sticky edge flags.
// - Delivers clean, clk-domain pin levels and events to the register bank and sequencer logic.

---
 rtl/dio_pkg.sv | 15 +
 rtl/dio_in_filter.sv | 48 ++++
 rtl/dio_in_conditioner.sv | 92 +++++++++
 tb/tb_dio_in_conditioner.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dio_pkg.sv
// Shared constants and types for the DIO input conditioner.
package dio_pkg;

    localparam int N_PINS_DEF = 8;
    localparam int FILT_W_DEF = 8;
    localparam int CNT_W_DEF  = 32;

    typedef logic [$clog2(N_PINS_DEF)-1:0] pin_idx_t;
    typedef logic [FILT_W_DEF-1:0]         filt_cnt_t;

    localparam logic      SYNC_RST_VAL  = 1'b0;
    localparam logic      LEVEL_RST_VAL = 1'b0;
    localparam filt_cnt_t FCNT_RST_VAL  = '0;

endpackage

// File: rtl/dio_in_filter.sv
// One DIO pin: two-flop synchroniser, glitch filter and registered rise/fall pulses.
module dio_in_filter
    import dio_pkg::*;
#(
    parameter int FILT_W = FILT_W_DEF
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              pin_raw,
    input  logic              is_input,
    input  logic [FILT_W-1:0] filt_len,
    output logic              level,
    output logic              rise,
    output logic              fall
);

    logic              sync_p0;
    logic              sync_p1;
    logic [FILT_W-1:0] fcnt;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sync_p0 <= SYNC_RST_VAL;
            sync_p1 <= SYNC_RST_VAL;
            fcnt    <= '0;
            level   <= LEVEL_RST_VAL;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_p0 <= pin_raw;
            sync_p1 <= sync_p0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            // fcnt never exceeds filt_len, so the increment cannot wrap
            if (sync_p1 == level) begin
                fcnt <= '0;
            end else if (fcnt >= filt_len) begin
                level <= sync_p1;
                fcnt  <= '0;
                rise  <= is_input & sync_p1;
                fall  <= is_input & ~sync_p1;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dio_in_conditioner.sv
// DIO pin-readback conditioner: per-pin filter, sticky edge flags and optional
// per-pin rising-edge counters enabled by defining DIO_EDGE_CNT_EN.
module dio_in_conditioner
    import dio_pkg::*;
#(
    parameter int  N_PINS = N_PINS_DEF,
    parameter int  FILT_W = FILT_W_DEF,
    parameter int  CNT_W  = CNT_W_DEF,
    localparam int SEL_W  = (N_PINS > 1) ? $clog2(N_PINS) : 1
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic [N_PINS-1:0] dio_in,
    input  logic [N_PINS-1:0] state,
    input  logic [FILT_W-1:0] filt_len,
    input  logic [N_PINS-1:0] flag_clr,
    input  logic [N_PINS-1:0] cnt_clr,
    input  logic [SEL_W-1:0]  cnt_sel,
    output logic [N_PINS-1:0] dio_filt,
    output logic [N_PINS-1:0] rise,
    output logic [N_PINS-1:0] fall,
    output logic [N_PINS-1:0] edge_flag,
    output logic [CNT_W-1:0]  cnt_value
);

    for (genvar i = 0; i < N_PINS; i++) begin : g_pin
        dio_in_filter #(
            .FILT_W(FILT_W)
        ) u_filter (
            .clk      (clk),
            .aresetn  (aresetn),
            .pin_raw  (dio_in[i]),
            .is_input (state[i]),
            .filt_len (filt_len),
            .level    (dio_filt[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
        );
    end

    // A new edge takes priority over a clear arriving in the same cycle
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            edge_flag <= '0;
        end else begin
            edge_flag <= (edge_flag & ~flag_clr) | rise | fall;
        end
    end

`ifdef DIO_EDGE_CNT_EN
    logic [CNT_W-1:0] cnt    [N_PINS];
    logic [CNT_W-1:0] rd_tbl [2**SEL_W];

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < N_PINS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_PINS; i++) begin
                if (cnt_clr[i]) begin
                    cnt[i] <= '0;
                end else if (rise[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Unused select codes read back as zero
    for (genvar i = 0; i < 2**SEL_W; i++) begin : g_rd
        if (i < N_PINS) begin : g_pin_rd
            assign rd_tbl[i] = cnt[i];
        end else begin : g_zero_rd
            assign rd_tbl[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_value <= '0;
        end else begin
            cnt_value <= rd_tbl[cnt_sel];
        end
    end
`else
    logic unused_cnt_in;
    assign unused_cnt_in = ^{cnt_clr, cnt_sel};
    assign cnt_value     = '0;
`endif

endmodule

// File: tb/tb_dio_in_conditioner.sv
// Self-checking bench for dio_in_conditioner: literal vector table, directed corner sequences
// and randomized traffic against a sample-history reference model.
module tb_dio_in_conditioner;

    localparam int N_PINS = 8;
    localparam int FILT_W = 8;
    localparam int CNT_W  = 4;
    localparam int SEL_W  = 3;
`ifdef DIO_EDGE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              aresetn;
    logic [N_PINS-1:0] dio_in, state, flag_clr, cnt_clr;
    logic [FILT_W-1:0] filt_len;
    logic [SEL_W-1:0]  cnt_sel;
    logic [N_PINS-1:0] dio_filt, rise, fall, edge_flag;
    logic [CNT_W-1:0]  cnt_value;

    dio_in_conditioner #(
        .N_PINS(N_PINS),
        .FILT_W(FILT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .aresetn   (aresetn),
        .dio_in    (dio_in),
        .state     (state),
        .filt_len  (filt_len),
        .flag_clr  (flag_clr),
        .cnt_clr   (cnt_clr),
        .cnt_sel   (cnt_sel),
        .dio_filt  (dio_filt),
        .rise      (rise),
        .fall      (fall),
        .edge_flag (edge_flag),
        .cnt_value (cnt_value)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [N_PINS-1:0] m_filt, m_rise, m_fall, m_flag;
    logic [CNT_W-1:0]  m_cnt [N_PINS];
    logic [CNT_W-1:0]  m_cntv;
    logic [N_PINS-1:0] hist [$];   // raw pin samples, newest first

    typedef struct {
        int              reps;
        logic [7:0]      dio;
        logic [7:0]      fclr;
        logic [7:0]      e_filt;
        logic [7:0]      e_rise;
        logic [7:0]      e_fall;
        logic [7:0]      e_flag;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(int reps, logic [7:0] dio, logic [7:0] fclr, logic [7:0] e_filt,
                                logic [7:0] e_rise, logic [7:0] e_fall, logic [7:0] e_flag);
        vec_t v;
        v.reps = reps; v.dio = dio; v.fclr = fclr;
        v.e_filt = e_filt; v.e_rise = e_rise; v.e_fall = e_fall; v.e_flag = e_flag;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_filt = '0; m_rise = '0; m_fall = '0; m_flag = '0; m_cntv = '0;
        for (int p = 0; p < N_PINS; p++) m_cnt[p] = '0;
        hist.delete();
    endtask

    // Synchronised sample seen k edges ago; the sync flops hold 0 before any history exists
    function automatic logic hbit(int idx, int p);
        if (idx < hist.size()) return hist[idx][p];
        return 1'b0;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    // A pin's filtered level flips once its last filt_len+1 synchronised samples all differ from it.
    task automatic model_edge();
        logic [N_PINS-1:0] nfilt, nr, nf;
        logic              commit;
        nfilt = m_filt; nr = '0; nf = '0;
        for (int p = 0; p < N_PINS; p++) begin
            commit = 1'b1;
            for (int j = 0; j <= int'(filt_len); j++)
                if (hbit(1 + j, p) == m_filt[p]) commit = 1'b0;
            if (commit) begin
                nfilt[p] = ~m_filt[p];
                nr[p]    = state[p] & nfilt[p];
                nf[p]    = state[p] & ~nfilt[p];
            end
        end
        m_flag = (m_flag & ~flag_clr) | m_rise | m_fall;
        m_cntv = (int'(cnt_sel) < N_PINS) ? m_cnt[cnt_sel] : '0;
        for (int p = 0; p < N_PINS; p++) begin
            if (cnt_clr[p])     m_cnt[p] = '0;
            else if (m_rise[p]) m_cnt[p] = m_cnt[p] + 1'b1;
        end
        m_filt = nfilt; m_rise = nr; m_fall = nf;
        hist.push_front(dio_in);
        if (hist.size() > 300) void'(hist.pop_back());
    endtask

    task automatic edge_only();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        edge_only();
        check("dio_filt", dio_filt, m_filt);
        check("rise", rise, m_rise);
        check("fall", fall, m_fall);
        check("edge_flag", edge_flag, m_flag);
        check("cnt_value", cnt_value, CNT_EN ? m_cntv : '0);
    endtask

    task automatic make_rise(input int p);
        dio_in[p] = 1'b1; tick(); tick();
        dio_in[p] = 1'b0; tick(); tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dio_filt"}, dio_filt, 0);
        check({tag, "_rise"}, rise, 0);
        check({tag, "_fall"}, fall, 0);
        check({tag, "_edge_flag"}, edge_flag, 0);
        check({tag, "_cnt_value"}, cnt_value, 0);
    endtask

    initial begin
        aresetn = 1'b0; dio_in = '0; state = 8'hFF; filt_len = 8'd4;
        flag_clr = '0; cnt_clr = '0; cnt_sel = '0;
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        aresetn = 1'b1;

        // Pin0 rise/fall at filt_len=4, pin3 short glitch, flag clear racing a fall
        tbl.push_back(mk( 1, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        tbl.push_back(mk( 5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        tbl.push_back(mk( 1, 8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00));
        tbl.push_back(mk( 1, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01));
        tbl.push_back(mk( 3, 8'h09, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01));
        tbl.push_back(mk(10, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01));
        tbl.push_back(mk( 6, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01));
        tbl.push_back(mk( 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01));
        tbl.push_back(mk( 1, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01));
        tbl.push_back(mk( 1, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00));
        tbl.push_back(mk( 2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        foreach (tbl[k]) begin
            dio_in = tbl[k].dio; flag_clr = tbl[k].fclr;
            for (int r = 0; r < tbl[k].reps; r++) begin
                edge_only();
                check($sformatf("tbl%0d_dio_filt", k), dio_filt, tbl[k].e_filt);
                check($sformatf("tbl%0d_rise", k), rise, tbl[k].e_rise);
                check($sformatf("tbl%0d_fall", k), fall, tbl[k].e_fall);
                check($sformatf("tbl%0d_edge_flag", k), edge_flag, tbl[k].e_flag);
            end
        end
        flag_clr = '0;

        // Output-direction pin: level follows readback, events suppressed
        state = 8'hFD; filt_len = 8'd0; cnt_sel = 3'd1; dio_in = 8'h02;
        tick(); tick(); tick();
        check("out_pin_filt_hi", dio_filt[1], 1'b1);
        check("out_pin_rise", rise[1], 1'b0);
        tick();
        check("out_pin_flag_hi", edge_flag[1], 1'b0);
        dio_in = 8'h00;
        tick(); tick(); tick();
        check("out_pin_filt_lo", dio_filt[1], 1'b0);
        check("out_pin_fall", fall[1], 1'b0);
        tick();
        check("out_pin_flag_lo", edge_flag[1], 1'b0);
        check("out_pin_cnt", cnt_value, 0);

        // Edge counter on pin2, then a clear coinciding with the 6th rise
        state = 8'hFF; cnt_sel = 3'd2;
        for (int n = 0; n < 5; n++) make_rise(2);
        tick(); tick();
        check("cnt5", cnt_value, CNT_EN ? 32'd5 : 32'd0);
        dio_in[2] = 1'b1;
        tick(); tick(); tick();
        check("rise6", rise[2], 1'b1);
        cnt_clr = 8'h04;
        tick();
        cnt_clr = 8'h00;
        tick();
        check("cnt_clr_wins", cnt_value, 0);
        dio_in[2] = 1'b0;
        tick(); tick(); tick();

        // Counter wrap on pin5, then a flag clear racing the final fall
        cnt_clr = 8'hFF; tick(); cnt_clr = 8'h00;
        cnt_sel = 3'd5;
        for (int n = 0; n < 17; n++) make_rise(5);
        tick();
        check("fall5", fall[5], 1'b1);
        flag_clr = 8'h20;
        tick();
        check("flag5_set_wins", edge_flag[5], 1'b1);
        tick();
        check("flag5_cleared", edge_flag[5], 1'b0);
        flag_clr = 8'h00;
        tick();
        check("cnt_wrap", cnt_value, CNT_EN ? 32'd1 : 32'd0);

        // Asynchronous reset in the middle of a pin7 filter count
        filt_len = 8'd4; dio_in = 8'h80;
        tick(); tick(); tick(); tick();
        #2 aresetn = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge clk);
        aresetn = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            tick();
            if (k == 5) check("post_reset_e5", dio_filt[7], 1'b0);
            if (k == 6) check("post_reset_e6", dio_filt[7], 1'b1);
        end

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if (c % 60 == 0)  filt_len = FILT_W'($urandom_range(0, 6));
            if (c % 45 == 0)  state = N_PINS'($urandom);
            for (int p = 0; p < N_PINS; p++)
                if ($urandom_range(0, 3) == 0) dio_in[p] = ~dio_in[p];
            flag_clr = ($urandom_range(0, 7) == 0) ? N_PINS'($urandom) : '0;
            cnt_clr  = ($urandom_range(0, 31) == 0) ? N_PINS'($urandom) : '0;
            cnt_sel  = SEL_W'($urandom);
            if (c == 700) begin
                #2 aresetn = 1'b0;
                #1;
                check_all_zero("rand_reset");
                model_reset();
                @(negedge clk);
                aresetn = 1'b1;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
